// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned REG_W  = 5;

  localparam logic [1:0] LOAD_USE_STALL = 2'd1;
  localparam logic [1:0] ALU_BR_STALL   = 2'd1;
  localparam logic [1:0] LOAD_BR_STALL  = 2'd2;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  // Register $0 is hardwired to zero and never produces a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] r,
                                     input logic [REG_W-1:0] dest);
    return (r != '0) && (r == dest);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// ID/EX-side signal bundle between the pipeline datapath and the hazard controller.
interface hazard_ctrl_unit_if #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
);
  logic [4:0]        IDRsReg;
  logic [4:0]        IDRtReg;
  logic              IDUsesRt;
  logic              IDBranch;
  logic              IDBranchTaken;
  logic              IDJump;
  logic [CTRL_W-1:0] ControlSigIn;
  logic              EXMemRead;
  logic              EXRegWrite;
  logic [4:0]        EXDestReg;
  logic [CTRL_W-1:0] ControlSigOut;
  logic              PCWrite;
  logic              IFIDWrite;
  logic              IFIDFlush;
  logic              Stalling;
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  FlushCount;

  // Datapath side: presents ID/EX fields, consumes pipeline enables.
  modport master (
    output IDRsReg, IDRtReg, IDUsesRt, IDBranch, IDBranchTaken, IDJump,
           ControlSigIn, EXMemRead, EXRegWrite, EXDestReg,
    input  ControlSigOut, PCWrite, IFIDWrite, IFIDFlush, Stalling,
           StallCount, FlushCount
  );

  // Hazard controller side.
  modport slave (
    input  IDRsReg, IDRtReg, IDUsesRt, IDBranch, IDBranchTaken, IDJump,
           ControlSigIn, EXMemRead, EXRegWrite, EXDestReg,
    output ControlSigOut, PCWrite, IFIDWrite, IFIDFlush, Stalling,
           StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_detect.sv
// Combinational hazard classification: number of bubbles the ID instruction needs.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  input  logic             i_uses_rt,
  input  logic             i_branch,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_reg_write,
  input  logic [REG_W-1:0] i_ex_dest,
  output logic [1:0]       o_need
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = reg_match(i_rs, i_ex_dest);
  assign w_rt_hit = reg_match(i_rt, i_ex_dest);

  // Branches compare both operands in ID, so they see rt regardless of IDUsesRt.
  always_comb begin
    o_need = '0;
    if (i_branch && i_ex_mem_read && (w_rs_hit || w_rt_hit))
      o_need = LOAD_BR_STALL;
    else if (i_ex_mem_read && (w_rs_hit || (i_uses_rt && w_rt_hit)))
      o_need = LOAD_USE_STALL;
    else if (i_branch && i_ex_reg_write && (w_rs_hit || w_rt_hit))
      o_need = ALU_BR_STALL;
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: stalls PC/IF-ID, bubbles ID/EX, flushes IF/ID.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned CTRL_W = hazard_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 16
) (
  input logic               Clk,
  input logic               Reset,
  hazard_ctrl_unit_if.slave bus
);

  hz_state_e   r_state, w_state_nxt;
  logic [1:0]  r_stall_left, w_stall_left_nxt;
  logic [1:0]  w_need;
  logic        w_stalling;
  logic        w_flush;

  hazard_detect u_detect (
    .i_rs           (bus.IDRsReg),
    .i_rt           (bus.IDRtReg),
    .i_uses_rt      (bus.IDUsesRt),
    .i_branch       (bus.IDBranch),
    .i_ex_mem_read  (bus.EXMemRead),
    .i_ex_reg_write (bus.EXRegWrite),
    .i_ex_dest      (bus.EXDestReg),
    .o_need         (w_need)
  );

  // State register and remaining-stall counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= RUN;
      r_stall_left <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_stall_left <= w_stall_left_nxt;
    end
  end

  // Next state: multi-cycle stalls park in STALL while EX holds the bubble.
  always_comb begin
    w_state_nxt      = r_state;
    w_stall_left_nxt = r_stall_left;
    case (r_state)
      RUN: begin
        if (w_need > 2'd1) begin
          w_state_nxt      = STALL;
          w_stall_left_nxt = w_need - 2'd1;
        end
      end
      STALL: begin
        if (r_stall_left <= 2'd1) begin
          w_state_nxt      = RUN;
          w_stall_left_nxt = '0;
        end else begin
          w_stall_left_nxt = r_stall_left - 2'd1;
        end
      end
      default: begin
        w_state_nxt      = RUN;
        w_stall_left_nxt = '0;
      end
    endcase
  end

  // Outputs: reset over stall over flush; branch outcome acted on only on release.
  always_comb begin
    w_stalling        = 1'b0;
    w_flush           = bus.IDJump || (bus.IDBranch && bus.IDBranchTaken);
    bus.PCWrite       = 1'b1;
    bus.IFIDWrite     = 1'b1;
    bus.ControlSigOut = bus.ControlSigIn;
    if (Reset) begin
      w_flush           = 1'b1;
      bus.PCWrite       = 1'b0;
      bus.IFIDWrite     = 1'b0;
      bus.ControlSigOut = '0;
    end else if (r_state == STALL || w_need != 2'd0) begin
      w_stalling        = 1'b1;
      w_flush           = 1'b0;
      bus.PCWrite       = 1'b0;
      bus.IFIDWrite     = 1'b0;
      bus.ControlSigOut = '0;
    end
  end

  assign bus.Stalling  = w_stalling;
  assign bus.IFIDFlush = w_flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating stall/flush event counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stalling && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && r_flush_cnt != '1)    r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.StallCount = r_stall_cnt;
  assign bus.FlushCount = r_flush_cnt;
`else
  assign bus.StallCount = '0;
  assign bus.FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: driver pushes hand-computed expectations,
// a negedge monitor pops and compares.
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.CTRL_W(16), .CNT_W(16)) bus ();

  hazard_ctrl_unit #(.CTRL_W(16), .CNT_W(16)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        pcw;
    logic        ifw;
    logic        flush;
    logic [15:0] ctrl;
    logic        stall;
    logic [15:0] scnt;
    logic [15:0] fcnt;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          vec_id   = 0;
  int unsigned m_scnt   = 0;
  int unsigned m_fcnt   = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=0x%0h want=0x%0h", name, id, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every applied vector presents a response.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("PCWrite",       e.id, 32'(bus.PCWrite),       32'(e.pcw));
      chk("IFIDWrite",     e.id, 32'(bus.IFIDWrite),     32'(e.ifw));
      chk("IFIDFlush",     e.id, 32'(bus.IFIDFlush),     32'(e.flush));
      chk("ControlSigOut", e.id, 32'(bus.ControlSigOut), 32'(e.ctrl));
      chk("Stalling",      e.id, 32'(bus.Stalling),      32'(e.stall));
      chk("StallCount",    e.id, 32'(bus.StallCount),    32'(e.scnt));
      chk("FlushCount",    e.id, 32'(bus.FlushCount),    32'(e.fcnt));
    end
  end

  task automatic step(
    input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
    input logic br, input logic tk, input logic jp, input logic [15:0] ci,
    input logic mr, input logic rw, input logic [4:0] dst,
    input logic e_pcw, input logic e_ifw, input logic e_fl,
    input logic [15:0] e_co, input logic e_st);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    bus.IDRsReg       = rs;
    bus.IDRtReg       = rt;
    bus.IDUsesRt      = ur;
    bus.IDBranch      = br;
    bus.IDBranchTaken = tk;
    bus.IDJump        = jp;
    bus.ControlSigIn  = ci;
    bus.EXMemRead     = mr;
    bus.EXRegWrite    = rw;
    bus.EXDestReg     = dst;
    e.pcw   = e_pcw;
    e.ifw   = e_ifw;
    e.flush = e_fl;
    e.ctrl  = e_co;
    e.stall = e_st;
    e.scnt  = 16'(m_scnt);
    e.fcnt  = 16'(m_fcnt);
    e.id    = vec_id;
    sb.push_back(e);
    vec_id++;
    // Counter model, applied at the edge that ends this vector.
    if (r) begin
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      if (e_st && m_scnt < 32'hFFFF) m_scnt++;
      if (e_fl && m_fcnt < 32'hFFFF) m_fcnt++;
`endif
    end
  endtask

  initial begin
    bus.IDRsReg = '0; bus.IDRtReg = '0; bus.IDUsesRt = 1'b0; bus.IDBranch = 1'b0;
    bus.IDBranchTaken = 1'b0; bus.IDJump = 1'b0; bus.ControlSigIn = '0;
    bus.EXMemRead = 1'b0; bus.EXRegWrite = 1'b0; bus.EXDestReg = '0;

    //   r  rs  rt ur br tk jp ctrl      mr rw dst  pcw ifw fl ctrl_out  st
    step(1, 8,  9, 1, 1, 1, 0, 16'h5555, 1, 0, 8,   0,  0,  1, 16'h0000, 0); // reset outputs
    step(1, 0,  0, 0, 0, 0, 0, 16'h0000, 0, 0, 0,   0,  0,  1, 16'h0000, 0);
    step(0, 1,  2, 1, 0, 0, 0, 16'h1234, 0, 0, 0,   1,  1,  0, 16'h1234, 0); // idle pass
    step(0, 8,  9, 1, 0, 0, 0, 16'hABCD, 1, 1, 8,   0,  0,  0, 16'h0000, 1); // load-use on rs
    step(0, 8,  9, 1, 0, 0, 0, 16'hABCD, 0, 0, 0,   1,  1,  0, 16'hABCD, 0); // released
    step(0, 3,  9, 1, 0, 0, 0, 16'h0F0F, 1, 1, 9,   0,  0,  0, 16'h0000, 1); // load-use on rt
    step(0, 3,  9, 0, 0, 0, 0, 16'h0F0F, 1, 1, 9,   1,  1,  0, 16'h0F0F, 0); // rt unused
    step(0, 0,  0, 1, 0, 0, 0, 16'h00F0, 1, 1, 0,   1,  1,  0, 16'h00F0, 0); // $0 never hazards
    step(0, 5,  6, 0, 1, 1, 0, 16'h0042, 0, 1, 5,   0,  0,  0, 16'h0000, 1); // ALU then branch
    step(0, 5,  6, 0, 1, 1, 0, 16'h0042, 0, 0, 0,   1,  1,  1, 16'h0042, 0); // taken, flush
    step(0, 8,  9, 0, 1, 1, 0, 16'h0077, 1, 1, 9,   0,  0,  0, 16'h0000, 1); // load then beq (rt)
    step(0, 8,  9, 0, 1, 1, 0, 16'h0077, 1, 1, 9,   0,  0,  0, 16'h0000, 1); // STALL cycle
    step(0, 8,  9, 0, 1, 1, 0, 16'h0077, 0, 0, 0,   1,  1,  1, 16'h0077, 0); // released, flush
    step(0, 1,  2, 0, 0, 0, 1, 16'h0300, 0, 0, 0,   1,  1,  1, 16'h0300, 0); // jump
    step(0, 1,  2, 0, 1, 0, 0, 16'h0400, 0, 0, 0,   1,  1,  0, 16'h0400, 0); // not taken
    step(0, 8,  9, 0, 1, 1, 0, 16'h0088, 1, 1, 8,   0,  0,  0, 16'h0000, 1); // load then beq
    step(1, 8,  9, 0, 1, 1, 0, 16'h0088, 0, 0, 0,   0,  0,  1, 16'h0000, 0); // reset in STALL
    step(0, 8,  9, 0, 1, 0, 0, 16'h0099, 0, 0, 0,   1,  1,  0, 16'h0099, 0); // fresh RUN
    step(0, 8,  9, 0, 0, 0, 0, 16'h00AA, 1, 1, 8,   0,  0,  0, 16'h0000, 1); // load-use again
    step(0, 8,  9, 1, 0, 0, 1, 16'h00BB, 0, 1, 9,   1,  1,  1, 16'h00BB, 0); // ALU dep, no branch

`ifdef HAZARD_PERF_CNT_EN
    // Drive StallCount past all-ones with back-to-back load-use stalls.
    for (int i = 0; i < 65540; i++)
      step(0, 8, 9, 1, 0, 0, 0, 16'h1111, 1, 1, 8,   0,  0,  0, 16'h0000, 1);
    step(0, 1,  2, 0, 0, 0, 1, 16'h2222, 0, 0, 0,   1,  1,  1, 16'h2222, 0);
    step(0, 1,  2, 0, 0, 0, 0, 16'h3333, 0, 0, 0,   1,  1,  0, 16'h3333, 0);
`endif

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
